// File: rtl/uart_rx_pkg.sv
// Shared UART constants, receiver state encoding and status layout.
// Status bit positions are mirrored in the software headers.
package configure;

  localparam int clks_per_bit = 216;

  localparam logic [31:0] uart_base_addr = 32'h1000_0000;
  localparam logic [31:0] uart_top_addr  = 32'h1000_000f;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_rx_state_t;

  localparam int RX_VALID_BIT = 8;
  localparam int RX_OVR_BIT   = 9;
  localparam int RX_FERR_BIT  = 10;

  function automatic logic [31:0] rx_status(
    input logic [7:0] data,
    input logic       valid,
    input logic       ovr,
    input logic       ferr
  );
    logic [31:0] w;
    w               = '0;
    w[7:0]          = data;
    w[RX_VALID_BIT] = valid;
    w[RX_OVR_BIT]   = ovr;
    w[RX_FERR_BIT]  = ferr;
    return w;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO; pointers carry a wrap bit to tell full from empty.
// A push into a full FIFO lands only if a pop happens in the same cycle.
module uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic             do_push;
  logic             do_pop;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) &&
                 (wptr_q[AW] != rptr_q[AW]);

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign rdata = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + (AW+1)'(1);
    if (do_pop)  rptr_d = rptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with receive FIFO, sticky error flags
// and a single-word memory-mapped read port.
module uart_rx
  import configure::*;
#(
  parameter int CLKS_PER_BIT = clks_per_bit,
  parameter int DEPTH        = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx,
  input  logic        uart_valid,
  input  logic [3:0]  uart_wstrb,
  output logic        uart_ready,
  output logic [31:0] uart_rdata
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MID = CW'(CLKS_PER_BIT / 2);

  uart_rx_state_t state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2:0]     idx_q, idx_d;
  logic [7:0]     sh_q, sh_d;
  logic [1:0]     sync_q;
  logic           rx_s;

  logic           ovr_q, ovr_d;
  logic           ferr_q, ferr_d;
  logic           ready_q, ready_d;
  logic [31:0]    rdata_q, rdata_d;

  logic           push;
  logic           ferr_set;
  logic           ovr_set;
  logic           accept;
  logic           rd;
  logic           pop;
  logic [7:0]     head;
  logic           empty;
  logic           full;

  assign rx_s = sync_q[1];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    sh_d     = sh_q;
    push     = 1'b0;
    ferr_set = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == CNT_MID) begin
          cnt_d = '0;
          idx_d = '0;
          state_d = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (cnt_q == CNT_MAX) begin
          sh_d  = {rx_s, sh_q[7:1]};
          cnt_d = '0;
          if (idx_q == 3'd7) state_d = STOP;
          else               idx_d   = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        // Leaving at mid-stop lets a back-to-back start bit be caught.
        if (cnt_q == CNT_MAX) begin
          push     = rx_s;
          ferr_set = ~rx_s;
          cnt_d    = '0;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    accept  = uart_valid & ~ready_q;
    rd      = accept & ~(|uart_wstrb);
    pop     = rd & ~empty;
    ovr_set = push & full & ~pop;
    ovr_d   = ovr_set | (ovr_q & ~rd);
    ferr_d  = ferr_set | (ferr_q & ~rd);
    ready_d = accept;
    rdata_d = rdata_q;
    if (accept) begin
      rdata_d = '0;
      if (rd) begin
        rdata_d = rx_status(empty ? 8'h00 : head,
                            ~empty, ovr_q, ferr_q);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      sync_q  <= 2'b11;
      ovr_q   <= 1'b0;
      ferr_q  <= 1'b0;
      ready_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      sync_q  <= {sync_q[0], rx};
      ovr_q   <= ovr_d;
      ferr_q  <= ferr_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
    end
  end

  uart_rx_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (sh_d),
    .rdata (head),
    .empty (empty),
    .full  (full)
  );

  assign uart_ready = ready_q;
  assign uart_rdata = rdata_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus random
// frames compared against a queue-based model of the receiver.
module tb_uart_rx;

  localparam int CPB   = 15;
  localparam int DEPTH = 4;
  localparam int BITC  = CPB + 1;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        rx = 1'b1;
  logic        uart_valid = 1'b0;
  logic [3:0]  uart_wstrb = 4'h0;
  logic        uart_ready;
  logic [31:0] uart_rdata;

  int checks = 0;
  int errors = 0;

  logic [7:0] mq[$];
  logic       movr = 1'b0;
  logic       mferr = 1'b0;

  always #5 clock = ~clock;

  uart_rx #(
    .CLKS_PER_BIT (CPB),
    .DEPTH        (DEPTH)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .rx         (rx),
    .uart_valid (uart_valid),
    .uart_wstrb (uart_wstrb),
    .uart_ready (uart_ready),
    .uart_rdata (uart_rdata)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Frame with explicit stop bit; the model absorbs it at frame end.
  task automatic send_frame(input logic [7:0] b, input logic stopb);
    logic [9:0] bits;
    bits = {stopb, b, 1'b0};
    @(posedge clock);
    #1;
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      tick(BITC);
    end
    rx = 1'b1;
    if (stopb) begin
      if (mq.size() < DEPTH) mq.push_back(b);
      else                   movr = 1'b1;
    end else begin
      mferr = 1'b1;
    end
    tick(20);
  endtask

  task automatic bus_read(input string tag);
    logic [31:0] exp;
    bit          got;
    exp = '0;
    exp[8]  = (mq.size() != 0);
    exp[9]  = movr;
    exp[10] = mferr;
    if (mq.size() != 0) exp[7:0] = mq.pop_front();
    movr  = 1'b0;
    mferr = 1'b0;
    @(posedge clock);
    #1;
    uart_valid = 1'b1;
    uart_wstrb = 4'h0;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      tick(1);
      if (uart_ready) got = 1'b1;
    end
    uart_valid = 1'b0;
    check({tag, "_rdy"}, {31'b0, uart_ready}, 32'd1);
    check(tag, uart_rdata, exp);
    tick(1);
  endtask

  task automatic bus_write(input string tag);
    @(posedge clock);
    #1;
    uart_valid = 1'b1;
    uart_wstrb = 4'hf;
    tick(1);
    check({tag, "_rdy"}, {31'b0, uart_ready}, 32'd1);
    check(tag, uart_rdata, 32'h0);
    tick(1);
    check({tag, "_norearm"}, {31'b0, uart_ready}, 32'd0);
    uart_valid = 1'b0;
    uart_wstrb = 4'h0;
    tick(1);
  endtask

  initial begin
    logic [7:0] rb;
    logic [7:0] pb;
    logic       rs;
    int         n;

    tick(3);
    check("reset_ready", {31'b0, uart_ready}, 32'd0);
    check("reset_rdata", uart_rdata, 32'h0);
    reset = 1'b0;
    tick(5);

    send_frame(8'h55, 1'b1);
    bus_read("valid_55");
    bus_read("valid_empty");

    @(posedge clock);
    #1 rx = 1'b0;
    tick(5);
    rx = 1'b1;
    tick(40);
    bus_read("glitch");

    send_frame(8'ha3, 1'b0);
    bus_read("ferr");
    bus_read("ferr_clr");

    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
    for (int i = 0; i < 5; i++) bus_read($sformatf("ovr_%0d", i));

    bus_read("pre_wr");
    bus_write("write");

    for (int i = 0; i < 4; i++) send_frame(8'h10 + 8'(i), 1'b1);
    // Stop sample lands 155 edges after the start bit is driven.
    fork
      send_frame(8'h14, 1'b1);
      begin
        @(posedge clock);
        repeat (153) @(posedge clock);
        bus_read("coll");
      end
    join
    for (int i = 0; i < 5; i++) bus_read($sformatf("coll_%0d", i));

    send_frame(8'h3c, 1'b1);
    send_frame(8'h5a, 1'b1);
    bus_read("pre_rst");
    pb = 8'ha8;
    @(posedge clock);
    #1 rx = 1'b0;
    tick(BITC);
    for (int i = 0; i < 3; i++) begin
      rx = pb[i];
      tick(BITC);
    end
    rx = pb[3];
    tick(8);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    mq.delete();
    movr  = 1'b0;
    mferr = 1'b0;
    check("rst_ready", {31'b0, uart_ready}, 32'd0);
    check("rst_rdata", uart_rdata, 32'h0);
    rx = 1'b1;
    tick(200);
    bus_read("rst_empty");
    send_frame(8'h7e, 1'b1);
    bus_read("rst_7e");

    for (int it = 0; it < 8; it++) begin
      n = $urandom_range(0, 5);
      for (int k = 0; k < n; k++) begin
        rb = 8'($urandom);
        rs = ($urandom_range(0, 7) != 0);
        send_frame(rb, rs);
      end
      n = $urandom_range(1, 3);
      for (int k = 0; k < n; k++)
        bus_read($sformatf("rnd_%0d_%0d", it, k));
    end
    while (mq.size() != 0) bus_read("drain");
    bus_read("final");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
